game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl_pkg.sv | 25 ++
 rtl/rise_edge.sv | 40 ++++
 rtl/game_state_ctrl.sv | 172 +++++++++++++++++
 tb/tb_game_state_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/game_state_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_state_ctrl_pkg
//  Description : Shared types and default parameter values for the game
//                state controller (state encoding, hit threshold, length of
//                the lose display and overlap counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package game_state_ctrl_pkg;

    // Game state encoding, explicit 2-bit width.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LOSE  = 2'd3
    } state_t;

    // Default parameter values used by game_state_ctrl.
    localparam int c_hit_thresh_default  = 4;
    localparam int c_lose_frames_default = 120;
    localparam int c_cnt_w_default       = 12;

endpackage : game_state_ctrl_pkg
`default_nettype wire

// File: rtl/rise_edge.sv
`default_nettype none
// ============================================================================
//  Module      : rise_edge
//  Description : 1-bit rising-edge detector with a registered history bit.
//                o_rise = i_d & ~prev, combinational in the cycle i_d rises.
//                The first cycle after reset release is never reported as an
//                edge, so a button already held while reset is released does
//                not count as a press until it is released and pressed again.
//  Ports       : i_clk   - clock
//                i_rst_n - asynchronous active-low reset
//                i_d     - synchronous, debounced level input
//                o_rise  - high for one cycle on a 0->1 transition of i_d
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;
    // Low only in the first cycle after reset: r_prev=0 then reflects the
    // reset value, not an observed low level of the button.
    logic r_armed;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_d;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = i_d & ~r_prev & r_armed;

endmodule : rise_edge
`default_nettype wire

// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_state_ctrl
//  Description : Game state machine (IDLE / RUN / PAUSE / LOSE). Counts
//                character/obstacle overlap pixels per frame, declares a hit
//                frame at end of frame, counts survived frames and times the
//                lose display before requesting a restart. All outputs are
//                registered.
//  Ports       : i_clk      - 100 MHz system clock
//                i_rst_n    - asynchronous active-low reset
//                i_pix_stb  - pixel strobe, one cycle per pixel
//                i_animate  - end-of-frame pulse
//                i_obj_px   - current pixel inside an obstacle
//                i_char_px  - current pixel inside the character
//                i_pause    - pause button (rising edge toggles pause)
//                i_start    - start button (rising edge starts play)
//                o_run      - high in RUN
//                o_paused   - high in PAUSE
//                o_lose     - high in LOSE
//                o_restart  - one-cycle pulse on leaving LOSE
//                o_frames   - frames survived in the current run
//  Revision    : 1.0 - initial release
// ============================================================================
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int HIT_THRESH  = c_hit_thresh_default,
    parameter int LOSE_FRAMES = c_lose_frames_default,
    parameter int CNT_W       = c_cnt_w_default
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_stb,
    input  logic        i_animate,
    input  logic        i_obj_px,
    input  logic        i_char_px,
    input  logic        i_pause,
    input  logic        i_start,
    output logic        o_run,
    output logic        o_paused,
    output logic        o_lose,
    output logic        o_restart,
    output logic [15:0] o_frames
);

    // Lose counter only needs to reach LOSE_FRAMES-1.
    localparam int                 c_lose_w    = (LOSE_FRAMES > 1) ? $clog2(LOSE_FRAMES) : 1;
    localparam logic [c_lose_w-1:0] c_lose_last = c_lose_w'(LOSE_FRAMES - 1);
    localparam logic [31:0]        c_hit_thresh = HIT_THRESH;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_ovl_cnt;
    logic [c_lose_w-1:0] r_lose_cnt;
    logic [15:0]         r_frames;
    logic                r_run;
    logic                r_paused;
    logic                r_lose;
    logic                r_restart;

    logic w_pause_rise;
    logic w_start_rise;
    logic w_overlap;
    logic w_hit;
    logic w_lose_done;

    rise_edge u_pause_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pause),
        .o_rise  (w_pause_rise)
    );

    rise_edge u_start_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_start),
        .o_rise  (w_start_rise)
    );

    assign w_overlap = i_pix_stb & i_obj_px & i_char_px;

    // Evaluated against the count accumulated before this cycle; the pixel
    // coinciding with i_animate is never counted.
    assign w_hit = (r_state == ST_RUN) && i_animate &&
                   (32'(r_ovl_cnt) >= c_hit_thresh);

    assign w_lose_done = (r_state == ST_LOSE) && i_animate &&
                         (r_lose_cnt == c_lose_last);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // Pause edges are ignored here; start wins when both arrive.
                if (w_start_rise) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A hit frame takes priority and drops a coincident pause edge.
                if (w_hit)             w_state_nxt = ST_LOSE;
                else if (w_pause_rise) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_pause_rise) w_state_nxt = ST_RUN;
            end
            ST_LOSE: begin
                if (w_lose_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_ovl_cnt  <= '0;
            r_lose_cnt <= '0;
            r_frames   <= '0;
            r_run      <= 1'b0;
            r_paused   <= 1'b0;
            r_lose     <= 1'b0;
            r_restart  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Overlap counter: cleared at every frame boundary, held at zero
            // outside RUN so a resumed frame starts from a clean count.
            if (r_state != ST_RUN || i_animate) begin
                r_ovl_cnt <= '0;
            end else if (w_overlap && (r_ovl_cnt != '1)) begin
                r_ovl_cnt <= r_ovl_cnt + 1'b1;
            end

            // Lose counter: zero outside LOSE, so entry always starts at 0.
            if (r_state != ST_LOSE) begin
                r_lose_cnt <= '0;
            end else if (i_animate && !w_lose_done) begin
                r_lose_cnt <= r_lose_cnt + 1'b1;
            end

            // Survived frames: cleared on start, kept through LOSE and IDLE
            // so the score stays visible until the next game.
            if (r_state == ST_IDLE && w_state_nxt == ST_RUN) begin
                r_frames <= '0;
            end else if (r_state == ST_RUN && i_animate && !w_hit &&
                         (r_frames != 16'hFFFF)) begin
                r_frames <= r_frames + 16'd1;
            end

            // Outputs are decoded from the next state so they line up with
            // the state register.
            r_run     <= (w_state_nxt == ST_RUN);
            r_paused  <= (w_state_nxt == ST_PAUSE);
            r_lose    <= (w_state_nxt == ST_LOSE);
            r_restart <= w_lose_done;
        end
    end

    assign o_run     = r_run;
    assign o_paused  = r_paused;
    assign o_lose    = r_lose;
    assign o_restart = r_restart;
    assign o_frames  = r_frames;

endmodule : game_state_ctrl
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_state_ctrl
//  Description : Directed self-checking testbench for game_state_ctrl with
//                default parameters (HIT_THRESH=4, LOSE_FRAMES=120).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_state_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_pix_stb = 1'b0;
    logic        i_animate = 1'b0;
    logic        i_obj_px = 1'b0;
    logic        i_char_px = 1'b0;
    logic        i_pause = 1'b0;
    logic        i_start = 1'b0;
    logic        o_run;
    logic        o_paused;
    logic        o_lose;
    logic        o_restart;
    logic [15:0] o_frames;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    game_state_ctrl u_dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_pix_stb (i_pix_stb),
        .i_animate (i_animate),
        .i_obj_px  (i_obj_px),
        .i_char_px (i_char_px),
        .i_pause   (i_pause),
        .i_start   (i_start),
        .o_run     (o_run),
        .o_paused  (o_paused),
        .o_lose    (o_lose),
        .o_restart (o_restart),
        .o_frames  (o_frames)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic press_start();
        i_start = 1'b1; tick();
        i_start = 1'b0; tick();
    endtask

    // n overlapping pixels, then the end-of-frame pulse; outputs sampled
    // right after the i_animate cycle.
    task automatic frame(input int n_ovl);
        for (int i = 0; i < n_ovl; i++) begin
            i_pix_stb = 1'b1; i_obj_px = 1'b1; i_char_px = 1'b1;
            tick();
            i_pix_stb = 1'b0; i_obj_px = 1'b0; i_char_px = 1'b0;
            tick();
        end
        i_animate = 1'b1; tick();
        i_animate = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (o_run !== 1'b0) begin n_errors++; $display("FAIL reset_run: got %b want 0", o_run); end
        n_checks++; if (o_paused !== 1'b0) begin n_errors++; $display("FAIL reset_paused: got %b want 0", o_paused); end
        n_checks++; if (o_lose !== 1'b0) begin n_errors++; $display("FAIL reset_lose: got %b want 0", o_lose); end
        n_checks++; if (o_restart !== 1'b0) begin n_errors++; $display("FAIL reset_restart: got %b want 0", o_restart); end
        n_checks++; if (o_frames !== 16'd0) begin n_errors++; $display("FAIL reset_frames: got %0d want 0", o_frames); end
        i_rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_run_frames();
        press_start();
        n_checks++; if (o_run !== 1'b1) begin n_errors++; $display("FAIL start_run: got %b want 1", o_run); end
        repeat (3) begin frame(0); tick(); end
        n_checks++; if (o_run !== 1'b1) begin n_errors++; $display("FAIL frames3_run: got %b want 1", o_run); end
        n_checks++; if (o_frames !== 16'd3) begin n_errors++; $display("FAIL frames3_count: got %0d want 3", o_frames); end
        n_checks++; if (o_lose !== 1'b0) begin n_errors++; $display("FAIL frames3_lose: got %b want 0", o_lose); end
    endtask

    task automatic test_hit_thresh();
        frame(3);
        n_checks++; if (o_lose !== 1'b0) begin n_errors++; $display("FAIL ovl3_lose: got %b want 0", o_lose); end
        n_checks++; if (o_frames !== 16'd4) begin n_errors++; $display("FAIL ovl3_frames: got %0d want 4", o_frames); end
        tick();
        frame(4);
        n_checks++; if (o_lose !== 1'b1) begin n_errors++; $display("FAIL ovl4_lose: got %b want 1", o_lose); end
        n_checks++; if (o_run !== 1'b0) begin n_errors++; $display("FAIL ovl4_run: got %b want 0", o_run); end
        n_checks++; if (o_frames !== 16'd4) begin n_errors++; $display("FAIL ovl4_frames: got %0d want 4", o_frames); end
    endtask

    task automatic test_lose_timeout();
        int restart_seen;
        restart_seen = 0;
        for (int i = 0; i < 119; i++) begin
            tick();
            frame(0);
            if (o_restart === 1'b1) restart_seen++;
        end
        n_checks++; if (o_lose !== 1'b1) begin n_errors++; $display("FAIL lose119_lose: got %b want 1", o_lose); end
        n_checks++; if (restart_seen !== 0) begin n_errors++; $display("FAIL lose119_restart: got %0d pulses want 0", restart_seen); end
        tick();
        frame(0);
        n_checks++; if (o_restart !== 1'b1) begin n_errors++; $display("FAIL lose120_restart: got %b want 1", o_restart); end
        n_checks++; if (o_lose !== 1'b0) begin n_errors++; $display("FAIL lose120_lose: got %b want 0", o_lose); end
        n_checks++; if (o_run !== 1'b0) begin n_errors++; $display("FAIL lose120_run: got %b want 0", o_run); end
        tick();
        n_checks++; if (o_restart !== 1'b0) begin n_errors++; $display("FAIL restart_width: got %b want 0", o_restart); end
        n_checks++; if (o_frames !== 16'd4) begin n_errors++; $display("FAIL idle_score: got %0d want 4", o_frames); end
    endtask

    task automatic test_idle_edges();
        i_pause = 1'b1; tick();
        i_pause = 1'b0; tick();
        n_checks++; if (o_paused !== 1'b0 || o_run !== 1'b0) begin n_errors++; $display("FAIL idle_pause: got run=%b paused=%b want 0 0", o_run, o_paused); end
        i_pause = 1'b1; i_start = 1'b1; tick();
        i_pause = 1'b0; i_start = 1'b0;
        n_checks++; if (o_run !== 1'b1 || o_paused !== 1'b0) begin n_errors++; $display("FAIL idle_both: got run=%b paused=%b want 1 0", o_run, o_paused); end
        n_checks++; if (o_frames !== 16'd0) begin n_errors++; $display("FAIL start_clears: got %0d want 0", o_frames); end
        tick();
    endtask

    task automatic test_pause();
        frame(0); tick();
        i_pause = 1'b1; tick();
        i_pause = 1'b0;
        n_checks++; if (o_paused !== 1'b1 || o_run !== 1'b0) begin n_errors++; $display("FAIL pause_on: got run=%b paused=%b want 0 1", o_run, o_paused); end
        tick();
        repeat (5) begin frame(5); tick(); end
        n_checks++; if (o_frames !== 16'd1) begin n_errors++; $display("FAIL pause_frozen: got %0d want 1", o_frames); end
        n_checks++; if (o_paused !== 1'b1 || o_lose !== 1'b0) begin n_errors++; $display("FAIL pause_ovl: got paused=%b lose=%b want 1 0", o_paused, o_lose); end
        i_pause = 1'b1; tick();
        i_pause = 1'b0;
        n_checks++; if (o_run !== 1'b1 || o_paused !== 1'b0) begin n_errors++; $display("FAIL pause_off: got run=%b paused=%b want 1 0", o_run, o_paused); end
        tick();
        frame(0);
        n_checks++; if (o_frames !== 16'd2 || o_lose !== 1'b0) begin n_errors++; $display("FAIL resume_frame: got frames=%0d lose=%b want 2 0", o_frames, o_lose); end
        tick();
    endtask

    task automatic test_pause_hit();
        for (int i = 0; i < 4; i++) begin
            i_pix_stb = 1'b1; i_obj_px = 1'b1; i_char_px = 1'b1; tick();
        end
        i_pix_stb = 1'b0; i_obj_px = 1'b0; i_char_px = 1'b0;
        i_animate = 1'b1; i_pause = 1'b1; tick();
        i_animate = 1'b0; i_pause = 1'b0;
        n_checks++; if (o_lose !== 1'b1 || o_paused !== 1'b0) begin n_errors++; $display("FAIL pause_hit: got lose=%b paused=%b want 1 0", o_lose, o_paused); end
        n_checks++; if (o_frames !== 16'd2) begin n_errors++; $display("FAIL pause_hit_frames: got %0d want 2", o_frames); end
        tick();
    endtask

    task automatic test_reset_in_lose();
        int restart_seen;
        restart_seen = 0;
        i_start = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++; if ({o_run, o_paused, o_lose, o_restart} !== 4'b0 || o_frames !== 16'd0) begin
            n_errors++; $display("FAIL async_reset: got run=%b paused=%b lose=%b restart=%b frames=%0d want all 0",
                                 o_run, o_paused, o_lose, o_restart, o_frames);
        end
        repeat (2) begin tick(); if (o_restart === 1'b1) restart_seen++; end
        #3 i_rst_n = 1'b1;
        repeat (4) begin tick(); if (o_restart === 1'b1) restart_seen++; end
        n_checks++; if (restart_seen !== 0) begin n_errors++; $display("FAIL reset_no_restart: got %0d pulses want 0", restart_seen); end
        n_checks++; if (o_run !== 1'b0) begin n_errors++; $display("FAIL held_start: got run=%b want 0", o_run); end
        i_start = 1'b0; tick();
        press_start();
        n_checks++; if (o_run !== 1'b1) begin n_errors++; $display("FAIL repress_start: got run=%b want 1", o_run); end
    endtask

    initial begin
        test_reset();
        test_run_frames();
        test_hit_thresh();
        test_lose_timeout();
        test_idle_edges();
        test_pause();
        test_pause_hit();
        test_reset_in_lose();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_game_state_ctrl
`default_nettype wire
